grid_vga_renderer: RTL and testbench

- Display-side reader of the 256-bit flattened Tetris playfield produced by the grid engine.
- Generates 640x480@60 VGA timing from the 100 MHz system clock using an internal 25 MHz pixel-enable.
- Snapshots the grid once per frame at vblank start, so a frame never shows a partial board.
- Draws the 16x16 playfield as solid cells, with black everywhere outside the playfield.

---
 rtl/grid_vga_renderer.sv | 155 +++++++++++++++
 tb/tb_grid_vga_renderer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/grid_vga_renderer.sv
// 640x480@60 VGA reader of the 16x16 playfield, snapshotted once per frame.
// Define GRID_LINES_EN to draw LINE_COLOR on the last row/column of each cell.
module grid_vga_renderer #(
  parameter int          CELL_PX    = 24,
  parameter int          ORIGIN_X   = 128,
  parameter int          ORIGIN_Y   = 48,
  parameter logic [11:0] FILL_COLOR = 12'hF80,
  parameter logic [11:0] BG_COLOR   = 12'h222,
  parameter logic [11:0] LINE_COLOR = 12'h555,
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] grid_in,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         frame_tick
);

  localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  localparam logic [9:0] HV  = 10'(H_VISIBLE);
  localparam logic [9:0] HS0 = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS1 = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] HL  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] VV  = 10'(V_VISIBLE);
  localparam logic [9:0] VS0 = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS1 = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] VL  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] FX0 = 10'(ORIGIN_X);
  localparam logic [9:0] FX1 = 10'(ORIGIN_X + 16 * CELL_PX);
  localparam logic [9:0] FY0 = 10'(ORIGIN_Y);
  localparam logic [9:0] FY1 = 10'(ORIGIN_Y + 16 * CELL_PX);
  localparam logic [PW-1:0] PXL = PW'(CELL_PX - 1);

  logic [1:0]    div_q;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [PW-1:0] px_x_q, px_x_d;
  logic [PW-1:0] px_y_q, px_y_d;
  logic [3:0]    cx_q, cx_d;
  logic [3:0]    cy_q, cy_d;
  logic [255:0]  shadow_q;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs_q, vs_q, vid_q, tick_q;

  logic pix_en, h_wrap, v_wrap;
  logic vis, in_field, line_px, snap;
  logic hs_d, vs_d;

  always_comb begin
    pix_en = (div_q == 2'd3);
    h_wrap = (h_q == HL);
    v_wrap = (v_q == VL);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;

    // Cell counters track the pixel that h_d/v_d will address.
    px_x_d = px_x_q + PW'(1);
    cx_d   = cx_q;
    if (h_d == FX0) begin
      px_x_d = '0;
      cx_d   = 4'd0;
    end else if (px_x_q == PXL) begin
      px_x_d = '0;
      cx_d   = cx_q + 4'd1;
    end

    px_y_d = px_y_q;
    cy_d   = cy_q;
    if (h_wrap) begin
      if (v_d == FY0) begin
        px_y_d = '0;
        cy_d   = 4'd0;
      end else if (px_y_q == PXL) begin
        px_y_d = '0;
        cy_d   = cy_q + 4'd1;
      end else begin
        px_y_d = px_y_q + PW'(1);
      end
    end

    vis      = (h_q < HV) && (v_q < VV);
    in_field = (h_q >= FX0) && (h_q < FX1) && (v_q >= FY0) && (v_q < FY1);
`ifdef GRID_LINES_EN
    line_px  = (px_x_q == PXL) || (px_y_q == PXL);
`else
    line_px  = 1'b0;
`endif
    rgb_d = 12'h000;
    if (vis && in_field) begin
      if (line_px)                       rgb_d = LINE_COLOR;
      else if (shadow_q[{cx_q, cy_q}])   rgb_d = FILL_COLOR;
      else                               rgb_d = BG_COLOR;
    end
    hs_d = !((h_q >= HS0) && (h_q < HS1));
    vs_d = !((v_q >= VS0) && (v_q < VS1));
    snap = pix_en && (h_q == 10'd0) && (v_q == VV);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q    <= 2'd0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      px_x_q   <= '0;
      px_y_q   <= '0;
      cx_q     <= 4'd0;
      cy_q     <= 4'd0;
      shadow_q <= '0;
      rgb_q    <= 12'h000;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vid_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q  <= div_q + 2'd1;
      tick_q <= snap;
      if (snap) shadow_q <= grid_in;
      if (pix_en) begin
        h_q    <= h_d;
        v_q    <= v_d;
        px_x_q <= px_x_d;
        px_y_q <= px_y_d;
        cx_q   <= cx_d;
        cy_q   <= cy_d;
        rgb_q  <= rgb_d;
        hs_q   <= hs_d;
        vs_q   <= vs_d;
        vid_q  <= vis;
      end
    end
  end

  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign video_on   = vid_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Bench for grid_vga_renderer: full-size instance for line timing,
// a shrunken-timing instance checked pixel by pixel against a model.
module tb_grid_vga_renderer;

  localparam int S_HV = 40, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VV = 36, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_CP = 2, S_OX = 4, S_OY = 2;
  localparam logic [15:0] RST_VEC = 16'h000C;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] grid = '0;

  logic [3:0] s_r, s_g, s_b, b_r, b_g, b_b;
  logic s_hs, s_vs, s_vid, s_ft, b_hs, b_vs, b_vid, b_ft;

  int n_chk = 0;
  int n_pass = 0;
  int mh, mv;
  logic [255:0] msh;
  logic [15:0] sq[$];

  always #5 clk = ~clk;

  grid_vga_renderer #(
    .CELL_PX(S_CP), .ORIGIN_X(S_OX), .ORIGIN_Y(S_OY),
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_dut (
    .clk(clk), .reset(reset), .grid_in(grid),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vid), .frame_tick(s_ft)
  );

  grid_vga_renderer u_big (
    .clk(clk), .reset(reset), .grid_in(grid),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vid), .frame_tick(b_ft)
  );

  function automatic logic [15:0] s_obs();
    return {s_r, s_g, s_b, s_hs, s_vs, s_vid, s_ft};
  endfunction

  function automatic logic [15:0] b_obs();
    return {b_r, b_g, b_b, b_hs, b_vs, b_vid, b_ft};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int h, input int v);
    logic [11:0] c;
    logic vis, hs, vs, ft, fld;
    int cx, cy;
    vis = (h < S_HV) && (v < S_VV);
    hs  = !((h >= S_HV + S_HF) && (h < S_HV + S_HF + S_HS));
    vs  = !((v >= S_VV + S_VF) && (v < S_VV + S_VF + S_VS));
    fld = (h >= S_OX) && (h < S_OX + 16 * S_CP) &&
          (v >= S_OY) && (v < S_OY + 16 * S_CP);
    ft  = (h == 0) && (v == S_VV);
    c   = 12'h000;
    if (vis && fld) begin
      cx = (h - S_OX) / S_CP;
      cy = (v - S_OY) / S_CP;
      c  = msh[cx * 16 + cy] ? 12'hF80 : 12'h222;
`ifdef GRID_LINES_EN
      if ((h - S_OX) % S_CP == S_CP - 1 || (v - S_OY) % S_CP == S_CP - 1)
        c = 12'h555;
`endif
    end
    return {c, hs, vs, vis, ft};
  endfunction

  task automatic pix(input int n);
    logic [15:0] e, o;
    for (int i = 0; i < n; i++) begin
      sq.push_back(model(mh, mv));
      if (mh == 0 && mv == S_VV) msh = grid;
      mh++;
      if (mh == S_HT) begin
        mh = 0;
        mv = (mv == S_VT - 1) ? 0 : mv + 1;
      end
      repeat (4) @(posedge clk);
      #1;
      o = s_obs();
      e = sq.pop_front();
      n_chk++;
      assert (o === e) n_pass++;
      else begin
        $error("FAIL pix h=%0d v=%0d observed=%h expected=%h",
               (mh + S_HT - 1) % S_HT, mv, o, e);
      end
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    mh = 0;
    mv = 0;
    msh = '0;
  endtask

  logic [255:0] corners, ones;
  int first_vid, first_fall, second_fall, hs_low0;
  int vid0, vid1, vs_low, rgb_nz, ticks;

  initial begin
    corners = '0;
    corners[0] = 1'b1;
    corners[255] = 1'b1;
    ones = '1;
    grid = corners;

    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_small", int'(s_obs()), int'(RST_VEC));
    chk("rst_big", int'(b_obs()), int'(RST_VEC));

    restart();
    first_vid = -1; first_fall = -1; second_fall = -1;
    hs_low0 = 0; vid0 = 0; vid1 = 0; vs_low = 0; rgb_nz = 0; ticks = 0;
    for (int n = 0; n < 6403; n++) begin
      @(posedge clk);
      #1;
      if (b_vid && first_vid < 0) first_vid = n;
      if (!b_hs && first_fall < 0) first_fall = n;
      if (!b_hs && first_fall >= 0 && n > first_fall + 384 && second_fall < 0)
        second_fall = n;
      if (!b_hs && n < 3203) hs_low0++;
      if (b_vid && n < 3203) vid0++;
      if (b_vid && n >= 3203) vid1++;
      if (!b_vs) vs_low++;
      if ({b_r, b_g, b_b} != 12'h000) rgb_nz++;
      if (b_ft) ticks++;
    end
    chk("first_video_clk", first_vid, 3);
    chk("hsync_first_fall", first_fall, 3 + 4 * 656);
    chk("hsync_low_clks", hs_low0, 384);
    chk("line_period", second_fall - first_fall, 3200);
    chk("video_clks_line0", vid0, 2560);
    chk("video_clks_line1", vid1, 2560);
    chk("vsync_low_top", vs_low, 0);
    chk("rgb_outside_field", rgb_nz, 0);
    chk("tick_top_lines", ticks, 0);

    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_again", int'(s_obs()), int'(RST_VEC));
    restart();

    pix(S_HT * S_VT);
    pix(S_HT * 10);
    grid = ones;
    pix(S_HT * (S_VT - 10));
    pix(S_HT * 20);

    grid = corners;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_midframe", int'(s_obs()), int'(RST_VEC));
    restart();
    pix(S_HT * S_VT + S_HT * 6);

    chk("queue_empty", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
